// File: rtl/power_squelch_if.sv
// ============================================================================
// power_squelch_if : run/settings/power-stream bundle for power_squelch
// Rev 1.0
// ============================================================================
`default_nettype none

interface power_squelch_if;
  logic        run;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] power_in;
  logic        strobe_in;
  logic [31:0] power_out;
  logic        strobe_out;
  logic        gate;
  logic        open_stb;
  logic        close_stb;
  logic [31:0] peak_out;
  logic [63:0] debug;

  modport master (
    output run, set_stb, set_addr, set_data, power_in, strobe_in,
    input  power_out, strobe_out, gate, open_stb, close_stb, peak_out, debug
  );

  modport slave (
    input  run, set_stb, set_addr, set_data, power_in, strobe_in,
    output power_out, strobe_out, gate, open_stb, close_stb, peak_out, debug
  );
endinterface

`default_nettype wire

// File: rtl/power_squelch.sv
// ============================================================================
// power_squelch : hysteresis squelch with attack/hang counts on a power stream.
// Optional peak tracking with POWER_SQUELCH_PEAK_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module power_squelch #(
  parameter logic [7:0] SR_THRESH_ON  = 8'd0,
  parameter logic [7:0] SR_THRESH_OFF = 8'd1,
  parameter logic [7:0] SR_COUNTS     = 8'd2,
  parameter logic [7:0] SR_SQ_ENABLE  = 8'd3
) (
  input  logic           clk,
  input  logic           reset,
  power_squelch_if.slave bus
);

  localparam logic [1:0] ST_CLOSED = 2'd0;
  localparam logic [1:0] ST_ATTACK = 2'd1;
  localparam logic [1:0] ST_OPEN   = 2'd2;
  localparam logic [1:0] ST_HANG   = 2'd3;

  logic [31:0] thresh_on_q, thresh_off_q;
  logic [7:0]  attack_q;
  logic [15:0] hang_q;
  logic        enable_q;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        gate_q, gate_d;
  logic        open_stb_q, open_stb_d;
  logic        close_stb_q, close_stb_d;
  logic        strobe_out_q;
  logic [31:0] power_out_q;

  logic [7:0]  attack_eff;
  logic [15:0] hang_eff;
  logic [15:0] cnt_inc;
  logic        above, below, advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      thresh_on_q  <= '0;
      thresh_off_q <= '0;
      attack_q     <= '0;
      hang_q       <= '0;
      enable_q     <= 1'b0;
    end else if (bus.set_stb) begin
      case (bus.set_addr)
        SR_THRESH_ON:  thresh_on_q  <= bus.set_data;
        SR_THRESH_OFF: thresh_off_q <= bus.set_data;
        SR_COUNTS: begin
          attack_q <= bus.set_data[7:0];
          hang_q   <= bus.set_data[23:8];
        end
        SR_SQ_ENABLE:  enable_q     <= bus.set_data[0];
        default: ;
      endcase
    end
  end

  logic unused_set_bits;
  assign unused_set_bits = &{1'b0, bus.set_data[31:24]};

  assign attack_eff = (attack_q == 8'd0) ? 8'd1 : attack_q;
  assign hang_eff   = (hang_q == 16'd0) ? 16'd1 : hang_q;
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
  assign above      = (bus.power_in >= thresh_on_q);
  assign below      = (bus.power_in < thresh_off_q);
  assign advance    = bus.strobe_in && enable_q && bus.run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLOSED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.run || !enable_q) begin
      state_d = ST_CLOSED;
      cnt_d   = '0;
    end else if (bus.strobe_in) begin
      case (state_q)
        ST_CLOSED: begin
          if (above) begin
            if (attack_eff == 8'd1) begin
              state_d = ST_OPEN;
              cnt_d   = '0;
            end else begin
              state_d = ST_ATTACK;
              cnt_d   = 16'd1;
            end
          end
        end
        ST_ATTACK: begin
          if (!above) begin
            state_d = ST_CLOSED;
            cnt_d   = '0;
          end else if (cnt_inc >= {8'd0, attack_eff}) begin
            state_d = ST_OPEN;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc;
          end
        end
        ST_OPEN: begin
          if (below) begin
            if (hang_eff == 16'd1) begin
              state_d = ST_CLOSED;
              cnt_d   = '0;
            end else begin
              state_d = ST_HANG;
              cnt_d   = 16'd1;
            end
          end
        end
        default: begin
          if (!below) begin
            state_d = ST_OPEN;
            cnt_d   = '0;
          end else if (cnt_inc >= hang_eff) begin
            state_d = ST_CLOSED;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc;
          end
        end
      endcase
    end
  end

  // Bypass forces the gate open; run=0 closes it silently without a close pulse.
  always_comb begin
    gate_d      = gate_q;
    open_stb_d  = 1'b0;
    close_stb_d = 1'b0;
    if (!enable_q) begin
      gate_d = 1'b1;
    end else if (!bus.run) begin
      gate_d = 1'b0;
    end else if (bus.strobe_in) begin
      gate_d      = (state_d == ST_OPEN) || (state_d == ST_HANG);
      open_stb_d  = ((state_q == ST_CLOSED) || (state_q == ST_ATTACK)) && (state_d == ST_OPEN);
      close_stb_d = ((state_q == ST_OPEN) || (state_q == ST_HANG)) && (state_d == ST_CLOSED);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_q       <= 1'b0;
      open_stb_q   <= 1'b0;
      close_stb_q  <= 1'b0;
      strobe_out_q <= 1'b0;
      power_out_q  <= '0;
    end else begin
      gate_q       <= gate_d;
      open_stb_q   <= open_stb_d;
      close_stb_q  <= close_stb_d;
      strobe_out_q <= bus.strobe_in;
      if (bus.strobe_in) begin
        power_out_q <= bus.power_in;
      end
    end
  end

`ifdef POWER_SQUELCH_PEAK_EN
  logic [31:0] peak_q, peak_d;
  logic [31:0] peak_out_q, peak_out_d;
  logic [31:0] peak_max;

  assign peak_max = (bus.power_in > peak_q) ? bus.power_in : peak_q;

  always_comb begin
    peak_d     = peak_q;
    peak_out_d = peak_out_q;
    if (open_stb_d) begin
      peak_d = bus.power_in;
    end else if (advance && ((state_q == ST_OPEN) || (state_q == ST_HANG))) begin
      peak_d = peak_max;
      if (close_stb_d) begin
        peak_out_d = peak_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q     <= '0;
      peak_out_q <= '0;
    end else begin
      peak_q     <= peak_d;
      peak_out_q <= peak_out_d;
    end
  end

  assign bus.peak_out = peak_out_q;
`else
  assign bus.peak_out = 32'h0;
`endif

  assign bus.power_out  = power_out_q;
  assign bus.strobe_out = strobe_out_q;
  assign bus.gate       = gate_q;
  assign bus.open_stb   = open_stb_q;
  assign bus.close_stb  = close_stb_q;
  assign bus.debug      = {state_q, cnt_q, gate_q, 45'd0};

endmodule

`default_nettype wire
